// File: rtl/tmds_period_scheduler.sv
// tmds_period_scheduler: pixel-clock sequencer between the three TMDS encoders
// and the 10:1 serializer. It schedules control, preamble, guard-band and video
// periods per line, and drives the constant clock-channel word. A 10-deep
// look-ahead delay line lets the preamble and guard band go out ahead of the
// first pixel of a line without dropping any pixels.
module tmds_period_scheduler #(
  parameter bit HDMI_MODE = 1'b1
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] tmds_0_in,
  input  logic [9:0] tmds_1_in,
  input  logic [9:0] tmds_2_in,
  output logic [9:0] datain_0,
  output logic [9:0] datain_1,
  output logic [9:0] datain_2,
  output logic [9:0] datain_3,
  output logic       video_active,
  output logic       gap_err
);

  localparam int unsigned DELAY = 10;

  localparam logic [9:0] CTRL_00  = 10'b1101010100;
  localparam logic [9:0] CTRL_01  = 10'b0010101011;
  localparam logic [9:0] CTRL_10  = 10'b0101010100;
  localparam logic [9:0] CTRL_11  = 10'b1010101011;
  localparam logic [9:0] GB0      = 10'b1011001100;
  localparam logic [9:0] GB1      = 10'b0100110011;
  localparam logic [9:0] CLK_WORD = 10'b1111100000;

  // Terminal counts: the counter restarts at 0 on entry, so PRE runs 8 cycles
  // and GUARD runs 2.
  localparam logic [3:0] PRE_LAST   = 4'd7;
  localparam logic [3:0] GUARD_LAST = 4'd1;

  typedef enum logic [1:0] {
    ST_CTRL,
    ST_PRE,
    ST_GUARD,
    ST_VIDEO
  } state_e;

  // Delay line: bit/entry 0 is the newest sample, DELAY-1 the oldest.
  logic [DELAY-1:0] de_sr_q;
  logic [DELAY-1:0] hs_sr_q;
  logic [DELAY-1:0] vs_sr_q;
  logic [29:0]      vid_sr_q [DELAY];

  // Outputs of the delay line (the look-ahead view of the line).
  logic        de_dly;
  logic        hs_dly;
  logic        vs_dly;
  logic [29:0] vid_dly;

  // A new line starts when de_in rises. If any active pixel of the previous
  // line is still inside the delay line, there is no room for a preamble.
  logic de_rise;
  logic line_in_flight;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  data0_d, data1_d, data2_d;
  logic        video_d;
  logic        gap_err_d;

  assign de_dly  = de_sr_q[DELAY-1];
  assign hs_dly  = hs_sr_q[DELAY-1];
  assign vs_dly  = vs_sr_q[DELAY-1];
  assign vid_dly = vid_sr_q[DELAY-1];

  assign de_rise        = de_in & ~de_sr_q[0];
  assign line_in_flight = |de_sr_q;

  // The clock channel carries the same 5-high/5-low word on every cycle.
  assign datain_3 = CLK_WORD;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_00;
      2'b01:   tok = CTRL_01;
      2'b10:   tok = CTRL_10;
      default: tok = CTRL_11;
    endcase
    return tok;
  endfunction

  // Shift sync, enable and encoded video through the 10-stage look-ahead.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      de_sr_q <= '0;
      hs_sr_q <= '0;
      vs_sr_q <= '0;
      for (int i = 0; i < DELAY; i++) begin
        vid_sr_q[i] <= '0;
      end
    end else begin
      de_sr_q     <= {de_sr_q[DELAY-2:0], de_in};
      hs_sr_q     <= {hs_sr_q[DELAY-2:0], hsync_in};
      vs_sr_q     <= {vs_sr_q[DELAY-2:0], vsync_in};
      vid_sr_q[0] <= {tmds_2_in, tmds_1_in, tmds_0_in};
      for (int i = 1; i < DELAY; i++) begin
        vid_sr_q[i] <= vid_sr_q[i-1];
      end
    end
  end

  // Next-state logic; the output words are chosen from the state being
  // entered so that they are registered together with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_err_d = 1'b0;

    unique case (state_q)
      ST_CTRL: begin
        if (de_dly) begin
          state_d = ST_VIDEO;
        end else if (HDMI_MODE && de_rise && !line_in_flight) begin
          state_d = ST_PRE;
          cnt_d   = 4'd0;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = de_dly ? ST_VIDEO : ST_CTRL;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_VIDEO: begin
        if (!de_dly) begin
          state_d = ST_CTRL;
        end
      end
      default: begin
        state_d = ST_CTRL;
        cnt_d   = 4'd0;
      end
    endcase

    // A line arriving too soon after the previous one is sent without a
    // preamble; flag it once. Rises during PRE/GUARD are ignored.
    if (HDMI_MODE && de_rise && line_in_flight &&
        (state_q == ST_CTRL || state_q == ST_VIDEO)) begin
      gap_err_d = 1'b1;
    end

    data0_d = ctrl_token({vs_dly, hs_dly});
    data1_d = CTRL_00;
    data2_d = CTRL_00;
    video_d = 1'b0;
    unique case (state_d)
      ST_PRE: begin
        data1_d = CTRL_01;
      end
      ST_GUARD: begin
        data0_d = GB0;
        data1_d = GB1;
        data2_d = GB0;
      end
      ST_VIDEO: begin
        data0_d = vid_dly[9:0];
        data1_d = vid_dly[19:10];
        data2_d = vid_dly[29:20];
        video_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Period FSM state, timing counter and registered serializer words.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q      <= ST_CTRL;
      cnt_q        <= 4'd0;
      datain_0     <= CTRL_00;
      datain_1     <= CTRL_00;
      datain_2     <= CTRL_00;
      video_active <= 1'b0;
      gap_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      datain_0     <= data0_d;
      datain_1     <= data1_d;
      datain_2     <= data2_d;
      video_active <= video_d;
      gap_err      <= gap_err_d;
    end
  end

endmodule
